tim1_dtg: RTL and testbench
===========================

# tim1_dtg

Dead-time generator and output controller for TIM1 channel 1. It takes the OC1REF compare reference and the channel enable/polarity bits held in the CCER register, and drives the complementary pin pair OC1/OC1N with programmable dead time. It also applies main-output-enable (MOE) gating, a synchronized break input and programmable idle levels. It sits between the TIM1 compare unit and the GPIO pins.

## Interface
- DTG_W, 8, dead-time counter width; dead time = i_dtg clk cycles.

- clk  in  1  timer kernel clock
- rst_n  in  1  asynchronous, active-low reset
- i_oc1ref  in  1  compare reference from the compare unit
- i_cc1E, i_cc1P, i_cc1NE, i_cc1NP  in  1 each  enable/polarity bits from CCER
- i_dtg  in  DTG_W  dead time in clk cycles
- i_moe  in  1  main output enable
- i_bke  in  1  break enable
- i_bkp  in  1  break active level
- i_brk  in  1  asynchronous break pin
- i_bif_clr  in  1  one-cycle pulse that clears the break flag
- i_ois1, i_ois1n  in  1 each  idle pin levels for OC1/OC1N
- o_oc1, o_oc1n  out  1 each  registered pin outputs
- o_moe_eff  out  1  effective MOE (i_moe AND NOT break latched)
- o_bif  out  1  sticky break flag
- o_dt_busy  out  1  high while in state DEAD

## Operation
- Break path:
  - i_brk passes through a 2-flop synchronizer to give brk_s.
  - The break event is i_bke=1 and brk_s==i_bkp. It sets o_bif and brk_lat.
  - o_bif and brk_lat clear only when i_bif_clr=1 and no break event occurs in the same cycle. If the break is still active, the clear is ignored.
- States:
  - IDLE: taken while o_moe_eff=0. o_oc1=i_ois1, o_oc1n=i_ois1n.
  - DEAD: both outputs inactive. cnt counts the dead time.
  - ON_P: OC1 side active.
  - ON_N: OC1N side active.
- Active outputs before polarity (act, actn):
  - ON_P: act=1, actn=0.
  - ON_N: act=0, actn=1.
  - DEAD: both 0.
  - Mode gating: E only → actn forced 0; NE only → OC1N follows the reference (ON_P maps to actn=0, ON_N to actn=1), OC1 forced 0; neither enabled → both 0.
- Pin level outside IDLE: o_oc1 = act XOR i_cc1P, o_oc1n = actn XOR i_cc1NP. Polarity bits take effect on the next edge, with no state change.
- Target state: tgt = ON_P if i_oc1ref=1, else ON_N.
- Transitions (evaluated at each edge; break and o_moe_eff have priority):
  - Any state → IDLE when o_moe_eff=0. cnt is cleared.
  - IDLE → DEAD (cnt=i_dtg) when o_moe_eff=1. If i_dtg=0, IDLE → tgt directly.
  - ON_x → DEAD (cnt=i_dtg) when tgt≠current state, or when {i_cc1E,i_cc1NE} changes. If i_dtg=0, the transition goes straight to tgt.
  - DEAD: a change in i_oc1ref or in the mode reloads cnt=i_dtg. Otherwise, cnt==1 → tgt; else cnt decrements.
- Narrow pulses: a reference pulse shorter than the dead time never asserts the pending output.
- i_dtg is sampled only at load time. Changing it during DEAD does not affect the running count.

## Timing
- Reset values: state=IDLE, cnt=0, sync flops=0, brk_lat=0, o_bif=0, o_moe_eff=0, o_oc1=0, o_oc1n=0, o_dt_busy=0.
- Reference edge sampled at edge k:
  - The deasserting output goes inactive after edge k.
  - The asserting output goes active after edge k+N, where N=i_dtg. This gives exactly N dead cycles; N=0 gives none.
- Break: the pin changes at edge j; o_bif and idle outputs appear after edge j+2 (synchronizer latency plus one register edge).
- i_moe falling at edge k gives idle levels after edge k.
- i_moe rising at edge k gives N dead cycles, then tgt.
- A break event and i_moe rising in the same cycle: break wins, and the state stays IDLE.
- rst_n low at any time forces reset values immediately. The first active edge after release evaluates normally from IDLE.

## Test plan
- Complementary dead time: E=NE=1, P=NP=0, dtg=3, moe=1, ref toggles every 10 cycles → OC1 and OC1N are never both 1. Each rising output lags the reference by 3 cycles; each falling output follows the reference 1 edge later.
- Glitch suppression and dtg=0:
  - dtg=5, 2-cycle ref pulse → OC1 stays 0 and OC1N shows a 2-cycle inactive gap, then recovers after 5 dead cycles.
  - dtg=0 → outputs are exact complements with 1 cycle of latency.
- Polarity and single-channel modes:
  - P=1, NP=1 → both pins inverted, dead cycles read 1/1.
  - NE=0 → o_oc1n=NP level throughout.
  - E=0, NE=1 → OC1N follows ref, OC1 inactive.
- Break sequence: bke=1, bkp=1, brk pulse 1 cycle → after 2 edges o_bif=1, outputs = ois1=1/ois1n=0.
  - i_bif_clr while brk still high → flag stays 1.
  - i_bif_clr after brk low → flag clears, then dtg dead cycles, then normal output.
- MOE and reset mid-operation:
  - moe drops while in ON_P → idle levels next edge.
  - rst_n asserted during DEAD → all outputs 0 immediately, o_bif=0, and the state restarts from IDLE.

Source files
------------

// File: rtl/tim1_dtg.sv
// tim1_dtg: TIM1 channel 1 dead-time generator and output controller.
// Drives the complementary OC1/OC1N pin pair from OC1REF. It inserts
// programmable dead time and applies MOE gating, a synchronized break
// input and idle levels.
module tim1_dtg #(
  parameter int unsigned DTG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_oc1ref,
  input  logic             i_cc1E,
  input  logic             i_cc1P,
  input  logic             i_cc1NE,
  input  logic             i_cc1NP,
  input  logic [DTG_W-1:0] i_dtg,
  input  logic             i_moe,
  input  logic             i_bke,
  input  logic             i_bkp,
  input  logic             i_brk,
  input  logic             i_bif_clr,
  input  logic             i_ois1,
  input  logic             i_ois1n,
  output logic             o_oc1,
  output logic             o_oc1n,
  output logic             o_moe_eff,
  output logic             o_bif,
  output logic             o_dt_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    ON_P = 2'd2,
    ON_N = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  state_t           tgt;
  state_t           load_state;
  logic [DTG_W-1:0] cnt;
  logic [DTG_W-1:0] cnt_nx;
  logic [DTG_W-1:0] load_cnt;

  logic             brk_m;
  logic             brk_s;
  logic             brk_lat;
  logic             ref_q;
  logic [1:0]       mode_q;

  logic             brk_ev;
  logic             lat_nx;
  logic             moe_nx;
  logic             mode_chg;
  logic             ref_chg;

  logic             act;
  logic             actn;
  logic             oc1_nx;
  logic             oc1n_nx;

  // Break event and the effective MOE seen by this edge; a break wins over a clear
  always_comb begin
    brk_ev   = i_bke && (brk_s == i_bkp);
    lat_nx   = brk_ev || (brk_lat && !i_bif_clr);
    moe_nx   = i_moe && !lat_nx;
    mode_chg = ({i_cc1E, i_cc1NE} != mode_q);
    ref_chg  = (i_oc1ref != ref_q);
    tgt      = i_oc1ref ? ON_P : ON_N;
    // A zero dead time skips DEAD and lands on the target directly
    if (i_dtg == '0) begin
      load_state = tgt;
      load_cnt   = '0;
    end else begin
      load_state = DEAD;
      load_cnt   = i_dtg;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic; loss of effective MOE overrides everything
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (!moe_nx) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = load_state;
          cnt_nx   = load_cnt;
        end
        ON_P, ON_N: begin
          if ((tgt != state) || mode_chg) begin
            state_nx = load_state;
            cnt_nx   = load_cnt;
          end
        end
        DEAD: begin
          if (ref_chg || mode_chg) begin
            state_nx = load_state;
            cnt_nx   = load_cnt;
          end else if (cnt <= DTG_W'(1)) begin
            state_nx = tgt;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - DTG_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state: active levels, mode gating, polarity
  always_comb begin
    act  = (state_nx == ON_P);
    actn = (state_nx == ON_N);
    case ({i_cc1E, i_cc1NE})
      2'b10:   actn = 1'b0;
      2'b01:   act  = 1'b0;
      2'b00: begin
        act  = 1'b0;
        actn = 1'b0;
      end
      default: ;
    endcase
    if (state_nx == IDLE) begin
      oc1_nx  = i_ois1;
      oc1n_nx = i_ois1n;
    end else begin
      oc1_nx  = act ^ i_cc1P;
      oc1n_nx = actn ^ i_cc1NP;
    end
  end

  // Break synchronizer, break latch, history flops and registered pin outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_m     <= 1'b0;
      brk_s     <= 1'b0;
      brk_lat   <= 1'b0;
      ref_q     <= 1'b0;
      mode_q    <= 2'b00;
      o_moe_eff <= 1'b0;
      o_oc1     <= 1'b0;
      o_oc1n    <= 1'b0;
      o_dt_busy <= 1'b0;
    end else begin
      brk_m     <= i_brk;
      brk_s     <= brk_m;
      brk_lat   <= lat_nx;
      ref_q     <= i_oc1ref;
      mode_q    <= {i_cc1E, i_cc1NE};
      o_moe_eff <= moe_nx;
      o_oc1     <= oc1_nx;
      o_oc1n    <= oc1n_nx;
      o_dt_busy <= (state_nx == DEAD);
    end
  end

  assign o_bif = brk_lat;

endmodule

// File: tb/tb_tim1_dtg.sv
// tb_tim1_dtg: directed and randomized bench for tim1_dtg with a
// behavioural model of the pin controller.
module tb_tim1_dtg;

  localparam int unsigned DTG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_oc1ref, i_cc1E, i_cc1P, i_cc1NE, i_cc1NP;
  logic [DTG_W-1:0] i_dtg;
  logic             i_moe, i_bke, i_bkp, i_brk, i_bif_clr, i_ois1, i_ois1n;
  logic             o_oc1, o_oc1n, o_moe_eff, o_bif, o_dt_busy;

  int total = 0;
  int bad   = 0;

  // Model state: phase 0=idle, 1=dead, 2=driving side m_side (1 = OC1 side)
  bit       m_s1, m_s2, m_lat;
  int       m_phase;
  bit       m_side;
  int       m_left;
  bit       m_pref;
  bit [1:0] m_pmode;
  bit       m_oc1, m_oc1n, m_moe, m_bif, m_busy;

  tim1_dtg #(.DTG_W(DTG_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_oc1ref(i_oc1ref),
    .i_cc1E(i_cc1E), .i_cc1P(i_cc1P), .i_cc1NE(i_cc1NE), .i_cc1NP(i_cc1NP),
    .i_dtg(i_dtg), .i_moe(i_moe), .i_bke(i_bke), .i_bkp(i_bkp),
    .i_brk(i_brk), .i_bif_clr(i_bif_clr), .i_ois1(i_ois1), .i_ois1n(i_ois1n),
    .o_oc1(o_oc1), .o_oc1n(o_oc1n), .o_moe_eff(o_moe_eff), .o_bif(o_bif),
    .o_dt_busy(o_dt_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lat = 0; m_phase = 0; m_side = 0; m_left = 0;
    m_pref = 0; m_pmode = 2'b00;
    m_oc1 = 0; m_oc1n = 0; m_moe = 0; m_bif = 0; m_busy = 0;
  endtask

  // Start a new dead interval toward the wanted side, or jump there with zero dead time
  task automatic model_begin_dead(input bit want);
    if (i_dtg == 0) begin
      m_phase = 2; m_side = want; m_left = 0;
    end else begin
      m_phase = 1; m_left = int'(i_dtg);
    end
  endtask

  task automatic model_edge();
    bit       ev, moe_e, want, a, an;
    bit [1:0] mode;
    ev    = i_bke && (m_s2 == i_bkp);
    m_lat = ev || (m_lat && !i_bif_clr);
    m_s2  = m_s1;
    m_s1  = i_brk;
    moe_e = i_moe && !m_lat;
    mode  = {i_cc1E, i_cc1NE};
    want  = i_oc1ref;
    if (!moe_e) begin
      m_phase = 0; m_left = 0;
    end else if (m_phase == 0) begin
      model_begin_dead(want);
    end else if (m_phase == 2) begin
      if (want != m_side || mode != m_pmode) model_begin_dead(want);
    end else begin
      if (i_oc1ref != m_pref || mode != m_pmode) model_begin_dead(want);
      else if (m_left <= 1) begin
        m_phase = 2; m_side = want; m_left = 0;
      end else m_left--;
    end
    if (m_phase == 0) begin
      m_oc1 = i_ois1; m_oc1n = i_ois1n;
    end else begin
      a  = (m_phase == 2) && m_side && mode[1];
      an = (m_phase == 2) && !m_side && mode[0];
      m_oc1  = a ^ i_cc1P;
      m_oc1n = an ^ i_cc1NP;
    end
    m_busy  = (m_phase == 1);
    m_moe   = moe_e;
    m_bif   = m_lat;
    m_pref  = i_oc1ref;
    m_pmode = mode;
  endtask

  // One clock: advance the model at the edge, compare on the falling edge
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    chk({tag, ".oc1"},  o_oc1,     m_oc1);
    chk({tag, ".oc1n"}, o_oc1n,    m_oc1n);
    chk({tag, ".moe"},  o_moe_eff, m_moe);
    chk({tag, ".bif"},  o_bif,     m_bif);
    chk({tag, ".busy"}, o_dt_busy, m_busy);
  endtask

  initial begin
    int gap;
    rst_n = 0; i_oc1ref = 0; i_cc1E = 1; i_cc1P = 0; i_cc1NE = 1; i_cc1NP = 0;
    i_dtg = 8'd3; i_moe = 0; i_bke = 0; i_bkp = 1; i_brk = 0; i_bif_clr = 0;
    i_ois1 = 0; i_ois1n = 0;
    model_reset();
    #1;
    chk("rst.oc1", o_oc1, 1'b0);
    chk("rst.oc1n", o_oc1n, 1'b0);
    chk("rst.moe", o_moe_eff, 1'b0);
    chk("rst.bif", o_bif, 1'b0);
    chk("rst.busy", o_dt_busy, 1'b0);
    @(negedge clk);
    rst_n = 1;

    // Complementary operation with dtg=3 and ref toggling every 10 cycles
    i_moe = 1;
    for (int c = 0; c < 10; c++) step("settle");
    for (int t = 0; t < 8; t++) begin
      i_oc1ref = ~i_oc1ref;
      for (int c = 1; c <= 10; c++) begin
        step("comp");
        chk("comp.nov", o_oc1 & o_oc1n, 1'b0);
        if (i_oc1ref) begin
          chk("comp.lat_oc1", o_oc1, 1'((c >= 4) ? 1 : 0));
          chk("comp.off_oc1n", o_oc1n, 1'b0);
        end else begin
          chk("comp.lat_oc1n", o_oc1n, 1'((c >= 4) ? 1 : 0));
          chk("comp.off_oc1", o_oc1, 1'b0);
        end
      end
    end

    // Narrow reference pulse shorter than the dead time
    i_dtg = 8'd5; i_oc1ref = 0;
    for (int c = 0; c < 12; c++) step("nar.settle");
    gap = 0;
    for (int c = 0; c < 16; c++) begin
      i_oc1ref = (c < 2);
      step("nar");
      chk("nar.oc1_quiet", o_oc1, 1'b0);
      if (!o_oc1n) gap++;
    end
    total++;
    assert (gap == 7) else begin
      bad++;
      $error("FAIL nar.gap observed=%0d expected=%0d", gap, 7);
    end

    // Zero dead time: exact complements one edge after the reference
    i_dtg = 8'd0;
    for (int c = 0; c < 30; c++) begin
      i_oc1ref = 1'($urandom_range(0, 1));
      step("dt0");
      chk("dt0.oc1", o_oc1, i_oc1ref);
      chk("dt0.oc1n", o_oc1n, ~i_oc1ref);
    end

    // Inverted polarity on both pins: dead cycles read 1/1, never both low
    i_dtg = 8'd2; i_cc1P = 1; i_cc1NP = 1;
    for (int c = 0; c < 40; c++) begin
      if (c % 6 == 0) i_oc1ref = ~i_oc1ref;
      step("pol");
      chk("pol.nov", o_oc1 | o_oc1n, 1'b1);
    end

    // OC1 only: OC1N holds its polarity level
    i_cc1P = 0; i_cc1NP = 1; i_cc1NE = 0;
    for (int c = 0; c < 30; c++) begin
      if (c % 7 == 0) i_oc1ref = ~i_oc1ref;
      step("e_only");
      chk("e_only.oc1n", o_oc1n, 1'b1);
    end

    // OC1N only: OC1 held inactive at its polarity level
    i_cc1E = 0; i_cc1NE = 1; i_cc1P = 1; i_cc1NP = 0;
    for (int c = 0; c < 30; c++) begin
      if (c % 7 == 0) i_oc1ref = ~i_oc1ref;
      step("ne_only");
      chk("ne_only.oc1", o_oc1, 1'b1);
    end

    // Break: one-cycle pin pulse, clear ignored while active, then honoured
    i_cc1E = 1; i_cc1NE = 1; i_cc1P = 0; i_cc1NP = 0; i_dtg = 8'd3;
    i_ois1 = 1; i_ois1n = 0; i_bke = 1; i_bkp = 1; i_oc1ref = 0;
    for (int c = 0; c < 6; c++) step("brk.settle");
    i_brk = 1;
    step("brk.j");
    i_brk = 0;
    step("brk.j1");
    chk("brk.j1.bif", o_bif, 1'b0);
    step("brk.j2");
    chk("brk.j2.bif", o_bif, 1'b1);
    chk("brk.j2.oc1", o_oc1, 1'b1);
    chk("brk.j2.oc1n", o_oc1n, 1'b0);
    i_brk = 1;
    for (int c = 0; c < 3; c++) step("brk.hold");
    i_bif_clr = 1;
    step("brk.clr_act");
    i_bif_clr = 0;
    chk("brk.clr_act.bif", o_bif, 1'b1);
    i_brk = 0;
    for (int c = 0; c < 3; c++) step("brk.drain");
    i_bif_clr = 1;
    step("brk.clr");
    i_bif_clr = 0;
    chk("brk.clr.bif", o_bif, 1'b0);
    chk("brk.clr.busy", o_dt_busy, 1'b1);
    for (int c = 0; c < 4; c++) step("brk.resume");
    chk("brk.resume.oc1n", o_oc1n, 1'b1);

    // MOE drop while OC1 is driving
    i_bke = 0; i_oc1ref = 1; i_ois1 = 0; i_ois1n = 1;
    for (int c = 0; c < 6; c++) step("moe.settle");
    chk("moe.on", o_oc1, 1'b1);
    i_moe = 0;
    step("moe.drop");
    chk("moe.drop.oc1", o_oc1, 1'b0);
    chk("moe.drop.oc1n", o_oc1n, 1'b1);

    // Reset asserted in the middle of a dead interval
    i_moe = 1; i_dtg = 8'd5;
    step("rst.dead1");
    step("rst.dead2");
    chk("rst.dead.busy", o_dt_busy, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("rst.async.oc1n", o_oc1n, 1'b0);
    chk("rst.async.busy", o_dt_busy, 1'b0);
    chk("rst.async.moe", o_moe_eff, 1'b0);
    model_reset();
    step("rst.held");
    rst_n = 1;
    step("rst.restart");
    chk("rst.restart.busy", o_dt_busy, 1'b1);

    // Randomized operation against the model
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 4) == 0) i_oc1ref = ~i_oc1ref;
      if ($urandom_range(0, 19) == 0) begin
        i_cc1E = 1'($urandom); i_cc1NE = 1'($urandom);
      end
      if ($urandom_range(0, 19) == 0) begin
        i_cc1P = 1'($urandom); i_cc1NP = 1'($urandom);
      end
      if ($urandom_range(0, 9) == 0) i_dtg = DTG_W'($urandom_range(0, 4));
      i_moe     = ($urandom_range(0, 15) != 0);
      i_bke     = ($urandom_range(0, 3) == 0);
      i_bkp     = 1'($urandom);
      if ($urandom_range(0, 5) == 0) i_brk = ~i_brk;
      i_bif_clr = ($urandom_range(0, 5) == 0);
      i_ois1    = 1'($urandom);
      i_ois1n   = 1'($urandom);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
